// File: rtl/dest_reg_bank_if.sv
// Command/status bundle for dest_reg_bank; master drives commands, slave is the pointer bank.
interface dest_reg_bank_if #(
    parameter int N  = 10,
    parameter int CH = 4,
    parameter int SW = 4,
    parameter int LW = 8
);
    localparam int CSW = (CH > 1) ? $clog2(CH) : 1;

    logic [CSW-1:0]  ch_sel;
    logic            pim_load;
    logic            mov_load;
    logic            upd_load;
    logic            cfg_load;
    logic            burst_start;
    logic [N-1:0]    d_in;
    logic [N-1:0]    mov_in;
    logic [SW-1:0]   stride_in;
    logic [N-1:0]    limit_in;
    logic [LW-1:0]   burst_len;
    logic [CH*N-1:0] q_all;
    logic [N-1:0]    q_sel;
    logic [CH-1:0]   wrap;
    logic            busy;
    logic            burst_done;

    modport master (
        output ch_sel, pim_load, mov_load, upd_load, cfg_load, burst_start,
        output d_in, mov_in, stride_in, limit_in, burst_len,
        input  q_all, q_sel, wrap, busy, burst_done
    );

    modport slave (
        input  ch_sel, pim_load, mov_load, upd_load, cfg_load, burst_start,
        input  d_in, mov_in, stride_in, limit_in, burst_len,
        output q_all, q_sel, wrap, busy, burst_done
    );
endinterface

// File: rtl/dest_reg_bank.sv
// CH-channel destination pointer bank with per-channel stride/limit and a single-channel burst stepper.
// Optional macro DEST_SAT_EN: steps saturate at limit instead of wrapping.
module dest_reg_bank #(
    parameter int N  = 10,
    parameter int CH = 4,
    parameter int SW = 4,
    parameter int LW = 8
) (
    input  logic             clk,
    input  logic             rst,
    dest_reg_bank_if.slave   bus
);
    localparam int CSW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q;
    logic [CSW-1:0] bch_q;
    logic [LW-1:0]  rem_q;
    logic           busy_q;
    logic           done_q;

    logic [N-1:0]   ptr_q    [CH];
    logic [N-1:0]   ptr_d    [CH];
    logic [SW-1:0]  stride_q [CH];
    logic [N-1:0]   limit_q  [CH];
    logic [CH-1:0]  wrap_q;
    logic [CH-1:0]  wrap_d;

    // Returns {wrap, next}; the test Q+stride > limit equals Q > limit-stride without underflow.
    function automatic logic [N:0] step_f(input logic [N-1:0] q, input logic [SW-1:0] s,
                                          input logic [N-1:0] lim);
        logic [N:0] sum;
        logic [N:0] rem;
        sum = {1'b0, q} + (N+1)'(s);
        rem = sum - ({1'b0, lim} + (N+1)'(1));
        if (s == '0)
            return {1'b0, q};
        if (sum > {1'b0, lim}) begin
`ifdef DEST_SAT_EN
            return {(q != lim), lim};
`else
            return {1'b1, rem[N-1:0]};
`endif
        end
        return {1'b0, sum[N-1:0]};
    endfunction

    always_comb begin
        logic       sel;
        logic       bstep;
        logic [N:0] st;
        wrap_d = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            ptr_d[k] = ptr_q[k];
            sel      = (bus.ch_sel == CSW'(k));
            bstep    = (state_q == RUN) && (bch_q == CSW'(k));
            st       = step_f(ptr_q[k], stride_q[k], limit_q[k]);
            if (sel && bus.pim_load) begin
                ptr_d[k] = bus.d_in;
            end else if (sel && bus.mov_load) begin
                ptr_d[k] = bus.mov_in;
            end else if (bstep || (sel && bus.upd_load)) begin
                ptr_d[k]  = st[N-1:0];
                wrap_d[k] = st[N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < CH; k++) begin
                ptr_q[k]    <= '0;
                stride_q[k] <= SW'(1);
                limit_q[k]  <= '1;
            end
            wrap_q <= '0;
        end else begin
            for (int unsigned k = 0; k < CH; k++) begin
                ptr_q[k] <= ptr_d[k];
                if (bus.cfg_load && (bus.ch_sel == CSW'(k))) begin
                    stride_q[k] <= bus.stride_in;
                    limit_q[k]  <= bus.limit_in;
                end
            end
            wrap_q <= wrap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bch_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.burst_start) begin
                        bch_q <= bus.ch_sel;
                        rem_q <= bus.burst_len;
                        if (bus.burst_len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.q_all = '0;
        bus.q_sel = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            bus.q_all[k*N +: N] = ptr_q[k];
            if (bus.ch_sel == CSW'(k))
                bus.q_sel = ptr_q[k];
        end
    end

    assign bus.wrap       = wrap_q;
    assign bus.busy       = busy_q;
    assign bus.burst_done = done_q;
endmodule

// File: tb/tb_dest_reg_bank.sv
// Directed-vector bench for dest_reg_bank; expected values are hand-computed constants.
module tb_dest_reg_bank;
    localparam int N   = 10;
    localparam int CH  = 4;
    localparam int SW  = 4;
    localparam int LW  = 8;
    localparam int CSW = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dest_reg_bank_if #(.N(N), .CH(CH), .SW(SW), .LW(LW)) bus();

    dest_reg_bank #(.N(N), .CH(CH), .SW(SW), .LW(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ptr(input int k);
        return bus.q_all[k*N +: N];
    endfunction

    task automatic clr();
        bus.ch_sel      = '0;
        bus.pim_load    = 1'b0;
        bus.mov_load    = 1'b0;
        bus.upd_load    = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.burst_start = 1'b0;
        bus.d_in        = '0;
        bus.mov_in      = '0;
        bus.stride_in   = '0;
        bus.limit_in    = '0;
        bus.burst_len   = '0;
    endtask

    // Commands set before cyc() are seen by exactly one edge; checks follow at edge+1.
    task automatic cyc();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic cfg(input int ch, input int s, input int lim);
        bus.ch_sel    = CSW'(ch);
        bus.cfg_load  = 1'b1;
        bus.stride_in = SW'(s);
        bus.limit_in  = N'(lim);
        cyc();
    endtask

    task automatic pim(input int ch, input int d);
        bus.ch_sel   = CSW'(ch);
        bus.pim_load = 1'b1;
        bus.d_in     = N'(d);
        cyc();
    endtask

    task automatic upd(input int ch);
        bus.ch_sel   = CSW'(ch);
        bus.upd_load = 1'b1;
        cyc();
    endtask

    task automatic burst(input int ch, input int len);
        bus.ch_sel      = CSW'(ch);
        bus.burst_start = 1'b1;
        bus.burst_len   = LW'(len);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q_all", bus.q_all, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.burst_done, 0);
        check("rst_wrap", bus.wrap, 0);
        rst = 1'b0;

        upd(0);
        check("upd_ch0_1", ptr(0), 1);
        upd(0);
        upd(0);
        bus.ch_sel = 2'd0;
        #1;
        check("q_sel_ch0", bus.q_sel, 3);
        bus.ch_sel = 2'd1;
        #1;
        check("q_sel_ch1", bus.q_sel, 0);

        cfg(1, 3, 10);
        pim(1, 9);
        check("pim_ch1", ptr(1), 9);
`ifdef DEST_SAT_EN
        cfg(1, 4, 10);
        pim(1, 8);
        upd(1);
        check("sat_first", ptr(1), 10);
        check("sat_wrap1", bus.wrap, 4'b0010);
        upd(1);
        check("sat_hold", ptr(1), 10);
        check("sat_wrap0", bus.wrap, 0);
        upd(1);
        check("sat_hold2", ptr(1), 10);
        check("sat_wrap0b", bus.wrap, 0);
`else
        upd(1);
        check("wrap_val", ptr(1), 1);
        check("wrap_pulse", bus.wrap, 4'b0010);
        cyc();
        check("wrap_clear", bus.wrap, 0);
        upd(1);
        check("step_nowrap", ptr(1), 4);
        pim(1, 7);
        upd(1);
        check("edge_val", ptr(1), 10);
        check("edge_nowrap", bus.wrap, 0);
        upd(1);
        check("edge_wrap_val", ptr(1), 2);
        check("edge_wrap", bus.wrap, 4'b0010);
        pim(1, 15);
        upd(1);
        check("above_lim", ptr(1), 7);
        check("above_wrap", bus.wrap, 4'b0010);
        pim(0, 1023);
        upd(0);
        check("mod_wrap_val", ptr(0), 0);
        check("mod_wrap", bus.wrap, 4'b0001);
`endif
        pim(0, 3);

        cfg(2, 0, 10);
        pim(2, 15);
        upd(2);
        check("stride0_val", ptr(2), 15);
        check("stride0_wrap", bus.wrap, 0);

        bus.ch_sel   = 2'd2;
        bus.pim_load = 1'b1;
        bus.mov_load = 1'b1;
        bus.upd_load = 1'b1;
        bus.d_in     = 10'd5;
        bus.mov_in   = 10'd7;
        cyc();
        check("prio_pim", ptr(2), 5);
        bus.ch_sel   = 2'd2;
        bus.mov_load = 1'b1;
        bus.mov_in   = 10'd7;
        cyc();
        check("prio_mov", ptr(2), 7);

        cfg(3, 2, 1023);
        burst(3, 4);
        check("b0_busy", bus.busy, 1);
        check("b0_q", ptr(3), 0);
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) begin
                bus.ch_sel      = 2'd0;
                bus.burst_start = 1'b1;
                bus.burst_len   = 8'd9;
                bus.upd_load    = 1'b1;
            end
            if (i == 3) begin
                bus.ch_sel   = 2'd3;
                bus.upd_load = 1'b1;
            end
            cyc();
            check("b_q", ptr(3), 64'(2 * i));
            check("b_busy", bus.busy, 64'(i < 4));
            check("b_done", bus.burst_done, 64'(i == 4));
            if (i == 2)
                check("b_other_upd", ptr(0), 4);
        end
        cyc();
        check("b_done_clear", bus.burst_done, 0);
        check("b_hold", ptr(3), 8);
        cyc();
        check("b_no_restart", bus.busy, 0);
        check("b_hold2", ptr(3), 8);

        burst(3, 4);
        cyc();
        check("m1_q", ptr(3), 10);
        bus.ch_sel   = 2'd3;
        bus.mov_load = 1'b1;
        bus.mov_in   = 10'd100;
        cyc();
        check("m2_mov", ptr(3), 100);
        check("m2_busy", bus.busy, 1);
        cyc();
        check("m3_q", ptr(3), 102);
        check("m3_done", bus.burst_done, 0);
        cyc();
        check("m4_q", ptr(3), 104);
        check("m4_done", bus.burst_done, 1);
        check("m4_busy", bus.busy, 0);
        cyc();

        burst(3, 5);
        cyc();
        check("r1_q", ptr(3), 106);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("r_q_all", bus.q_all, 0);
        check("r_busy", bus.busy, 0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("r_no_done", bus.burst_done, 0);
            check("r_idle", bus.busy, 0);
        end
        check("r_q_hold", bus.q_all, 0);

        burst(1, 0);
        check("z_done", bus.burst_done, 1);
        check("z_busy", bus.busy, 0);
        check("z_q", ptr(1), 0);
        cyc();
        check("z_done_clear", bus.burst_done, 0);

        bus.ch_sel    = 2'd0;
        bus.cfg_load  = 1'b1;
        bus.stride_in = 4'd5;
        bus.limit_in  = 10'd1023;
        bus.upd_load  = 1'b1;
        cyc();
        check("cfg_old_stride", ptr(0), 1);
        upd(0);
        check("cfg_new_stride", ptr(0), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
